// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line constants, the byte serializer state encoding,
// and the status-byte length decode used by both the transmitter and the receiver.
package midi_pkg;

    localparam int unsigned MIDI_BAUD                 = 31250;
    localparam int unsigned MIDI_DEFAULT_CLKS_PER_BIT = 1600;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Total message length in bytes (status included) implied by a status byte.
    function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd1;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: begin
                case (status[3:0])
                    4'h2:       len = 2'd3;
                    4'h1, 4'h3: len = 2'd2;
                    default:    len = 2'd1;
                endcase
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

    function automatic logic is_channel_status(input logic [7:0] status);
        return status[7] && (status[7:4] != 4'hF);
    endfunction

endpackage

// File: rtl/midi_tx_if.sv
// Message handshake between the sequencer (master) and the MIDI transmitter (slave).
interface midi_tx_if;

    logic        msg_valid;
    logic        msg_ready;
    logic [23:0] msg_bytes;

    modport master (
        output msg_valid,
        output msg_bytes,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_bytes,
        output msg_ready
    );

endinterface

// File: rtl/midi_tx_byte.sv
// Single-byte 8N1 serializer. A load is taken in IDLE or on the final stop-bit
// cycle, so back-to-back bytes leave no gap on the line. CLKS_PER_BIT must be >= 2.
module midi_tx_byte
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = MIDI_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       serial_o,
    output logic       done_o
);

    localparam int unsigned     CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             serial_q;
    logic             done_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, so it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (load_i) begin
                        state_q  <= START;
                        serial_q <= 1'b0;
                        shift_q  <= byte_i;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q    <= '0;
                        state_q  <= DATA;
                        serial_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q  <= STOP;
                            serial_q <= 1'b1;
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            serial_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (load_i) begin
                            state_q  <= START;
                            serial_q <= 1'b0;
                            shift_q  <= byte_i;
                        end else begin
                            state_q  <= IDLE;
                            serial_q <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        // Registered pulse lands on the last stop-bit cycle.
                        done_q <= (cnt_q == CNT_PRE);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_o = serial_q;
    assign done_o   = done_q;

endmodule

// File: rtl/midi_tx.sv
// MIDI 1.0 message transmitter: accepts a 1-3 byte message and sends its bytes
// back to back at 31250 baud. Optional running status: MIDI_TX_RUNNING_STATUS_EN.
module midi_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = MIDI_DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    midi_tx_if.slave    msg_if,
    output logic        serial_out_o,
    output logic        busy_o,
    output logic        byte_done_o
);

    logic [23:0] msg_q, msg_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_idx_q, last_idx_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic [7:0]  status;
    logic [1:0]  first_idx;
    logic        load;
    logic [7:0]  load_byte;
    logic        byte_done;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0]  last_status_q, last_status_d;
`endif

    function automatic logic [7:0] pick_byte(input logic [23:0] msg, input logic [1:0] idx);
        case (idx)
            2'd0:    return msg[7:0];
            2'd1:    return msg[15:8];
            default: return msg[23:16];
        endcase
    endfunction

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        accept     = msg_if.msg_valid && ready_q;
        status     = msg_if.msg_bytes[7:0];
        first_idx  = 2'd0;
        msg_d      = msg_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        load       = 1'b0;
        load_byte  = 8'h00;

`ifdef MIDI_TX_RUNNING_STATUS_EN
        // Channel status repeats are dropped; system common clears the memory,
        // real-time and data bytes leave it untouched.
        last_status_d = last_status_q;
        if (accept) begin
            if (is_channel_status(status)) begin
                if (status == last_status_q) begin
                    first_idx = 2'd1;
                end
                last_status_d = status;
            end else if (status[7:3] == 5'b11110) begin
                last_status_d = '0;
            end
        end
`endif

        if (accept) begin
            msg_d      = msg_if.msg_bytes;
            idx_d      = first_idx;
            last_idx_d = midi_msg_len(status) - 2'd1;
            busy_d     = 1'b1;
            ready_d    = 1'b0;
            load       = 1'b1;
            load_byte  = pick_byte(msg_if.msg_bytes, first_idx);
        end else if (busy_q && byte_done) begin
            if (idx_q == last_idx_q) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end else begin
                idx_d     = idx_q + 2'd1;
                load      = 1'b1;
                load_byte = pick_byte(msg_q, idx_q + 2'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            msg_q      <= msg_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

`ifdef MIDI_TX_RUNNING_STATUS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_status_q <= '0;
        end else begin
            last_status_q <= last_status_d;
        end
    end
`endif

    midi_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .byte_i   (load_byte),
        .serial_o (serial_out_o),
        .done_o   (byte_done)
    );

    assign msg_if.msg_ready = ready_q;
    assign busy_o           = busy_q;
    assign byte_done_o      = byte_done;

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: directed scenarios plus random messages,
// compared against a message-level model of the MIDI framing rules.
module tb_midi_tx;

    localparam int unsigned C     = 16;
    localparam int unsigned FRAME = 10 * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic serial_out;
    logic busy;
    logic byte_done;

    midi_tx_if bus ();

    midi_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_if       (bus),
        .serial_out_o (serial_out),
        .busy_o       (busy),
        .byte_done_o  (byte_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bytes that should appear on the line for message m.
    task automatic model_msg(input logic [23:0] m, output int len, output logic [23:0] payload);
        logic [7:0] s;
        int         full;
        int         skip;
        s    = m[7:0];
        skip = 0;
        if (s < 8'h80)                   full = 1;
        else if (s >= 8'hF0)             full = (s == 8'hF2) ? 3 : ((s == 8'hF1 || s == 8'hF3) ? 2 : 1);
        else if (s >= 8'hC0 && s < 8'hE0) full = 2;
        else                             full = 3;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (s >= 8'h80 && s <= 8'hEF) begin
            if (s == model_last) skip = 1;
            else                 model_last = s;
        end else if (s >= 8'hF0 && s <= 8'hF7) begin
            model_last = 8'h00;
        end
`endif
        len     = full - skip;
        payload = m >> (8 * skip);
    endtask

    // Starts and ends on a falling edge; poke_at >= 0 pulses a rogue message mid-frame.
    task automatic send(input logic [23:0] m, input bit hold, input int poke_at, input string tag);
        int          len;
        logic [23:0] pay;
        logic [9:0]  fbits;
        logic [7:0]  eb;
        int          k;
        int          fi;
        int          ndone;
        int          bad_done;
        bus.msg_valid = 1'b1;
        bus.msg_bytes = m;
        check($sformatf("%s/ready_before", tag), 32'(bus.msg_ready), 32'd1);
        model_msg(m, len, pay);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.msg_valid = 1'b0;
        bus.msg_bytes = 24'($urandom);
        check($sformatf("%s/ready_busy", tag), 32'(bus.msg_ready), 32'd0);
        k        = 0;
        ndone    = 0;
        bad_done = 0;
        fbits    = '0;
        while (busy === 1'b1 && k < 3 * FRAME + 8) begin
            if (k == poke_at) begin
                bus.msg_valid = 1'b1;
                bus.msg_bytes = 24'h7F7F80;
            end else if (poke_at >= 0 && k == poke_at + 1) begin
                bus.msg_valid = 1'b0;
            end
            if (k % C == C / 2) fbits[(k % FRAME) / C] = serial_out;
            if (byte_done === 1'b1) begin
                ndone++;
                if (k % FRAME != FRAME - 1) bad_done++;
            end
            if (k % FRAME == FRAME - 1) begin
                fi = k / FRAME;
                eb = (fi < 3) ? pay[8*fi +: 8] : 8'hXX;
                check($sformatf("%s/frame%0d", tag, fi), 32'(fbits), 32'({1'b1, eb, 1'b0}));
            end
            k++;
            @(negedge clk);
        end
        check($sformatf("%s/busy_cycles", tag), 32'(k), 32'(len * FRAME));
        check($sformatf("%s/done_count", tag), 32'(ndone), 32'(len));
        check($sformatf("%s/done_misplaced", tag), 32'(bad_done), 32'd0);
        check($sformatf("%s/ready_after", tag), 32'(bus.msg_ready), 32'd1);
        check($sformatf("%s/line_idle", tag), 32'(serial_out), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stat_tbl [16];
        int         target;
        int         len;
        logic [23:0] pay;

        stat_tbl = '{8'h80, 8'h9F, 8'hA3, 8'hB1, 8'hC5, 8'hD0, 8'hE7, 8'hF0,
                     8'hF1, 8'hF2, 8'hF3, 8'hF6, 8'hF8, 8'hFE, 8'h3C, 8'h90};

        bus.msg_valid = 1'b0;
        bus.msg_bytes = 24'h0;
        repeat (3) @(negedge clk);
        check("reset/serial", 32'(serial_out), 32'd1);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/byte_done", 32'(byte_done), 32'd0);
        check("reset/ready", 32'(bus.msg_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle/serial", 32'(serial_out), 32'd1);

        // Note On, program change (upper byte dropped), timing clock back to back.
        send(24'h643C90, 1'b0, -1, "note_on");
        send(24'hFF07C5, 1'b0, -1, "prog_chg");
        send(24'h0000F8, 1'b1, -1, "clock_a");
        send(24'h0000F8, 1'b0, -1, "clock_b");

        // Rogue message while busy must be ignored.
        send(24'h643C90, 1'b0, 200, "poke");
        @(negedge clk);
        check("poke/stays_idle", 32'(busy), 32'd0);

        // Reset in the middle of bit 3 of data1.
        bus.msg_valid = 1'b1;
        bus.msg_bytes = 24'h643C85;
        model_msg(24'h643C85, len, pay);
        @(posedge clk);
        @(negedge clk);
        bus.msg_valid = 1'b0;
        target = (len == 3 ? FRAME : 0) + 4 * C + C / 2;
        for (int i = 0; i < target; i++) @(negedge clk);
        check("rst_mid/bit3", 32'(serial_out), 32'd1);
        check("rst_mid/busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid/serial", 32'(serial_out), 32'd1);
        check("rst_mid/busy", 32'(busy), 32'd0);
        check("rst_mid/ready", 32'(bus.msg_ready), 32'd1);
        check("rst_mid/byte_done", 32'(byte_done), 32'd0);
        rst_n      = 1'b1;
        model_last = 8'h00;
        @(negedge clk);
        send(24'h643C90, 1'b0, -1, "after_rst");

`ifdef MIDI_TX_RUNNING_STATUS_EN
        send(24'h643C90, 1'b0, -1, "rs_a");
        send(24'h403E90, 1'b0, -1, "rs_b");
        send(24'h0000F8, 1'b0, -1, "rs_rt");
        send(24'h003C90, 1'b0, -1, "rs_c");
        send(24'h0000F6, 1'b0, -1, "rs_sys");
        send(24'h003C90, 1'b0, -1, "rs_d");
`endif

        for (int n = 0; n < 12; n++) begin
            logic [23:0] m;
            m = {8'($urandom), 8'($urandom), stat_tbl[$urandom_range(0, 15)]};
            send(m, 1'b0, -1, $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
